// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one multi-cycle memory port with response timeout
// Optional MEM_ARB_RR_EN selects round-robin on ties; default is data-over-fetch priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_wen,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int MW = DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                state, state_next;
    logic                  owner_d;
    logic                  lat_wen;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [MW-1:0]         lat_wmask;
    logic [TW-1:0]         tcnt;
    logic                  grant_d;
    logic                  resp_fire;
    logic                  timeout_fire;
    logic                  done;

`ifdef MEM_ARB_RR_EN
    logic last_grant_d;

    // On a tie, hand the port to whoever did not get it last time.
    assign grant_d = d_req && (!if_req || !last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (state == IDLE && (if_req || d_req)) begin
            last_grant_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign resp_fire    = (state == RESP) && mem_resp_valid;
    // A response arriving in the expiry cycle takes precedence over the error.
    assign timeout_fire = (TIMEOUT_CYCLES != 0) && (state == RESP) && !mem_resp_valid
                          && (tcnt == TW'(TIMEOUT_CYCLES));
    assign done         = resp_fire || timeout_fire;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (if_req || d_req) state_next = REQ;
            REQ:     if (mem_ready)       state_next = RESP;
            RESP:    if (done)            state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            tcnt      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (if_req || d_req)) begin
                owner_d   <= grant_d;
                lat_wen   <= grant_d && d_wen;
                lat_addr  <= grant_d ? d_addr : if_addr;
                lat_wdata <= grant_d ? d_wdata : '0;
                lat_wmask <= (grant_d && d_wen) ? d_wmask : '0;
            end
            if (state == REQ) begin
                tcnt <= '0;
            end else if (state == RESP && !done) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign mem_valid = (state == REQ);
    assign mem_wen   = lat_wen;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_wmask = lat_wmask;
    assign busy      = (state != IDLE);

    assign if_rvalid = done && !owner_d;
    assign if_err    = timeout_fire && !owner_d;
    assign if_rdata  = (resp_fire && !owner_d) ? mem_rdata : '0;
    assign d_rvalid  = done && owner_d;
    assign d_err     = timeout_fire && owner_d;
    assign d_rdata   = (resp_fire && owner_d && !lat_wen) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Advance one clock; returns 1 ns after the following negedge.
    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Both requesters held; runs one transaction from IDLE and checks who won.
    task automatic tie_txn(input logic exp_d, input int n);
        logic [31:0] a;
        a = exp_d ? 32'h0000_0100 : 32'h0000_0200;
        cyc;
        chk($sformatf("tie%0d_addr", n), mem_addr, a);
        cyc;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1000 + n;
        #1;
        chk($sformatf("tie%0d_drv", n), {31'd0, d_rvalid}, {31'd0, exp_d});
        chk($sformatf("tie%0d_irv", n), {31'd0, if_rvalid}, {31'd0, !exp_d});
        cyc;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_wen = 0; d_addr = '0;
        d_wdata = '0; d_wmask = '0; mem_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
        cyc; cyc;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        rst = 1'b0;

        // fetch read, minimum turnaround
        if_req = 1; if_addr = 32'h8000_0000; mem_ready = 1;
        #1 chk("t1_c0_mem_valid", {31'd0, mem_valid}, 32'd0);
        cyc;
        chk("t1_c1_mem_valid", {31'd0, mem_valid}, 32'd1);
        chk("t1_c1_addr", mem_addr, 32'h8000_0000);
        chk("t1_c1_wen", {31'd0, mem_wen}, 32'd0);
        chk("t1_c1_wmask", {28'd0, mem_wmask}, 32'd0);
        cyc;
        mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        #1;
        chk("t1_c2_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t1_c2_if_rdata", if_rdata, 32'h0000_0413);
        chk("t1_c2_if_err", {31'd0, if_err}, 32'd0);
        chk("t1_c2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        if_req = 0;
        cyc;
        mem_resp_valid = 0;
        chk("t1_c3_busy", {31'd0, busy}, 32'd0);

        // store
        d_req = 1; d_wen = 1; d_addr = 32'h8000_1004; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
        cyc;
        chk("t2_mem_wen", {31'd0, mem_wen}, 32'd1);
        chk("t2_mem_wmask", {28'd0, mem_wmask}, 32'hF);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_addr", mem_addr, 32'h8000_1004);
        cyc;
        mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t2_d_rdata", d_rdata, 32'd0);
        chk("t2_if_rdata", if_rdata, 32'd0);
        d_req = 0; d_wen = 0;
        cyc;
        mem_resp_valid = 0;

        // simultaneous requests from a fresh reset
        rst = 1; cyc; rst = 0;
        if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h100;
`ifdef MEM_ARB_RR_EN
        tie_txn(1'b1, 0); tie_txn(1'b0, 1); tie_txn(1'b1, 2);
`else
        tie_txn(1'b1, 0); tie_txn(1'b1, 1); tie_txn(1'b1, 2);
`endif
        if_req = 0; d_req = 0;

        // backpressure; payload stays latched even as the requester's inputs move
        mem_ready = 0; d_req = 1; d_addr = 32'h300;
        cyc;
        d_addr = 32'h999;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_valid%0d", i), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("t4_addr%0d", i), mem_addr, 32'h300);
            chk($sformatf("t4_rv%0d", i), {31'd0, d_rvalid}, 32'd0);
            if (i == 4) mem_ready = 1;
            cyc;
        end
        mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t4_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 0;
        cyc;
        mem_resp_valid = 0;

        // timeout after four silent RESP cycles
        d_req = 1; d_addr = 32'h400; mem_rdata = 32'h5555_AAAA;
        cyc; cyc;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_wait_rv%0d", i), {31'd0, d_rvalid}, 32'd0);
            cyc;
        end
        chk("t5_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t5_d_err", {31'd0, d_err}, 32'd1);
        chk("t5_d_rdata", d_rdata, 32'd0);
        d_req = 0;
        cyc;
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        mem_resp_valid = 1;
        #1 chk("t5_late_ignored", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        mem_resp_valid = 0;

        // response on the expiry cycle beats the timeout
        d_req = 1; d_addr = 32'h440;
        cyc; cyc;
        for (int i = 0; i < 4; i++) cyc;
        mem_resp_valid = 1; mem_rdata = 32'h0BAD_CAFE;
        #1;
        chk("t5b_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t5b_d_err", {31'd0, d_err}, 32'd0);
        chk("t5b_d_rdata", d_rdata, 32'h0BAD_CAFE);
        d_req = 0;
        cyc;
        mem_resp_valid = 0;

        // reset while waiting in RESP
        if_req = 1; if_addr = 32'h500;
        cyc; cyc;
        chk("t6_busy_resp", {31'd0, busy}, 32'd1);
        rst = 1;
        cyc;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("t6_no_rvalid", {31'd0, if_rvalid}, 32'd0);
        rst = 0; if_addr = 32'h600;
        cyc;
        chk("t6_new_addr", mem_addr, 32'h600);
        cyc;
        mem_resp_valid = 1; mem_rdata = 32'h0000_ABCD;
        #1;
        chk("t6_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("t6_if_rdata", if_rdata, 32'h0000_ABCD);
        if_req = 0;
        cyc;
        mem_resp_valid = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
